// File: rtl/path_datapath.sv
// Grid-walker datapath: current location register, single-step mover,
// location stack for backtracking, step counter and sticky error flags.
module path_datapath #(
  parameter int unsigned     CW    = 4,
  parameter int unsigned     DEPTH = 16,
  parameter int unsigned     SW    = 8,
  parameter logic [2*CW-1:0] START = '0,
  parameter logic [2*CW-1:0] GOAL  = '1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rgLd,
  input  logic [1:0]               dir,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     readFromStack,
  input  logic                     clrErr,
  output logic [2*CW-1:0]          curLoc,
  output logic [2*CW-1:0]          nxtLoc,
  output logic                     edgeHit,
  output logic                     atGoal,
  output logic                     empStck,
  output logic                     fullStck,
  output logic [$clog2(DEPTH):0]   stckCnt,
  output logic [SW-1:0]            stepCnt,
  output logic                     ovfErr,
  output logic                     unfErr,
  output logic                     bndErr
);

  localparam int unsigned LW   = 2 * CW;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  logic [LW-1:0]   cur_q, cur_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [SW-1:0]   step_q, step_d;
  logic            ovf_q, ovf_d, unf_q, unf_d, bnd_q, bnd_d;
  logic [LW-1:0]   mem_q [DEPTH];

  logic [CW-1:0]   x_c, y_c, sel_c, stepped_c;
  logic            axis_c, edge_c, emp_c, full_c;
  logic [LW-1:0]   step_loc_c, top_c, nxt_c;
  logic            rej_bnd_c, rej_unf_c, acc_c;
  logic            we_c, ovf_ev_c, unf_ev_c;
  logic [AW-1:0]   waddr_c;

  assign emp_c  = (cnt_q == '0);
  assign full_c = (cnt_q == CNTW'(DEPTH));
  assign top_c  = mem_q[AW'(cnt_q - CNTW'(1))];

  // Single-step mover: dir picks axis (parity) and sign (lsb)
  always_comb begin
    x_c       = cur_q[LW-1:CW];
    y_c       = cur_q[CW-1:0];
    axis_c    = ^dir;
    sel_c     = axis_c ? x_c : y_c;
    edge_c    = dir[0] ? (sel_c == '1) : (sel_c == '0);
    stepped_c = dir[0] ? sel_c + CW'(1) : sel_c - CW'(1);
    step_loc_c = axis_c ? {stepped_c, y_c} : {x_c, stepped_c};
    if (readFromStack) nxt_c = emp_c ? cur_q : top_c;
    else               nxt_c = step_loc_c;
  end

  // Next-state: location load, stack bookkeeping, counters and error flags
  always_comb begin
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    we_c     = 1'b0;
    waddr_c  = AW'(cnt_q);
    ovf_ev_c = 1'b0;
    unf_ev_c = 1'b0;

    rej_bnd_c = rgLd & ~readFromStack & edge_c;
    rej_unf_c = rgLd & readFromStack & emp_c;
    acc_c     = rgLd & ~rej_bnd_c & ~rej_unf_c;

    if (acc_c) begin
      cur_d = nxt_c;
      if (step_q != '1) step_d = step_q + SW'(1);
    end

    if (push && pop && !emp_c) begin
      we_c    = 1'b1;
      waddr_c = AW'(cnt_q - CNTW'(1));
    end else if (push) begin
      if (full_c) begin
        ovf_ev_c = 1'b1;
      end else begin
        we_c  = 1'b1;
        cnt_d = cnt_q + CNTW'(1);
      end
    end else if (pop) begin
      if (emp_c) unf_ev_c = 1'b1;
      else       cnt_d = cnt_q - CNTW'(1);
    end

    // A fresh error event overrides a same-cycle clear
    ovf_d = (ovf_q & ~clrErr) | ovf_ev_c;
    unf_d = (unf_q & ~clrErr) | unf_ev_c | rej_unf_c;
    bnd_d = (bnd_q & ~clrErr) | rej_bnd_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q  <= START;
      cnt_q  <= '0;
      step_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      bnd_q  <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      bnd_q  <= bnd_d;
    end
  end

  // Stack RAM has no reset; writes are blocked while rst is asserted
  always_ff @(posedge clk) begin
    if (we_c && !rst) mem_q[waddr_c] <= cur_q;
  end

  assign curLoc   = cur_q;
  assign nxtLoc   = nxt_c;
  assign edgeHit  = edge_c;
  assign atGoal   = (cur_q == GOAL);
  assign empStck  = emp_c;
  assign fullStck = full_c;
  assign stckCnt  = cnt_q;
  assign stepCnt  = step_q;
  assign ovfErr   = ovf_q;
  assign unfErr   = unf_q;
  assign bndErr   = bnd_q;

endmodule

// File: tb/tb_path_datapath.sv
// Directed bench for path_datapath with default parameters (4x4-bit grid,
// 16-entry stack, START=0x00, GOAL=0xFF).
module tb_path_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic       rgLd, push, pop, readFromStack, clrErr;
  logic [1:0] dir;
  logic [7:0] curLoc, nxtLoc;
  logic       edgeHit, atGoal, empStck, fullStck;
  logic [4:0] stckCnt;
  logic [7:0] stepCnt;
  logic       ovfErr, unfErr, bndErr;

  int errors = 0;
  int checks = 0;

  path_datapath dut (
    .clk(clk), .rst(rst), .rgLd(rgLd), .dir(dir), .push(push), .pop(pop),
    .readFromStack(readFromStack), .clrErr(clrErr),
    .curLoc(curLoc), .nxtLoc(nxtLoc), .edgeHit(edgeHit), .atGoal(atGoal),
    .empStck(empStck), .fullStck(fullStck), .stckCnt(stckCnt),
    .stepCnt(stepCnt), .ovfErr(ovfErr), .unfErr(unfErr), .bndErr(bndErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of controls, then return all controls to idle
  task automatic cyc(input logic ld, input logic [1:0] d, input logic ps,
                     input logic pp, input logic rfs, input logic clr);
    rgLd = ld; dir = d; push = ps; pop = pp; readFromStack = rfs; clrErr = clr;
    @(posedge clk); #1;
    rgLd = 0; push = 0; pop = 0; readFromStack = 0; clrErr = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; rgLd = 0; dir = 2'b00; push = 0; pop = 0; readFromStack = 0; clrErr = 0;
    #2;
    chk("rst_cur",  32'(curLoc),  32'h00);
    chk("rst_cnt",  32'(stckCnt), 32'd0);
    chk("rst_step", 32'(stepCnt), 32'd0);
    chk("rst_emp",  32'(empStck), 32'd1);
    chk("rst_errs", 32'({ovfErr, unfErr, bndErr}), 32'd0);
    chk("rst_goal", 32'(atGoal),  32'd0);
    @(posedge clk); #1 rst = 0;

    // Step test
    dir = 2'b01; #1;
    chk("nxt_xinc", 32'(nxtLoc), 32'h10);
    cyc(1, 2'b01, 0, 0, 0, 0);
    chk("step1_cur",  32'(curLoc),  32'h10);
    chk("step1_cnt",  32'(stepCnt), 32'd1);
    cyc(1, 2'b11, 0, 0, 0, 0);
    chk("step2_cur",  32'(curLoc),  32'h11);
    cyc(1, 2'b10, 0, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 0, 0);
    chk("back_origin", 32'(curLoc), 32'h00);
    chk("step4_cnt",  32'(stepCnt), 32'd4);

    // Boundary test
    dir = 2'b00; #1;
    chk("edge_ydec", 32'(edgeHit), 32'd1);
    cyc(1, 2'b00, 0, 0, 0, 0);
    chk("bnd_cur",  32'(curLoc),  32'h00);
    chk("bnd_err",  32'(bndErr),  32'd1);
    chk("bnd_step", 32'(stepCnt), 32'd4);
    cyc(1, 2'b00, 0, 0, 0, 1);
    chk("clr_vs_new_err", 32'(bndErr), 32'd1);
    cyc(0, 2'b00, 0, 0, 0, 1);
    chk("bnd_cleared", 32'(bndErr), 32'd0);

    // Stack fill: push old location while stepping x up, then push alone
    for (int i = 0; i < 15; i++) cyc(1, 2'b01, 1, 0, 0, 0);
    chk("fill_cur",  32'(curLoc),  32'hF0);
    chk("fill_step", 32'(stepCnt), 32'd19);
    chk("fill_cnt15", 32'(stckCnt), 32'd15);
    cyc(0, 2'b00, 1, 0, 0, 0);
    chk("full_flag", 32'(fullStck), 32'd1);
    chk("full_cnt",  32'(stckCnt),  32'd16);
    chk("full_noovf", 32'(ovfErr),  32'd0);
    cyc(0, 2'b00, 1, 0, 0, 0);
    chk("ovf_err", 32'(ovfErr),  32'd1);
    chk("ovf_cnt", 32'(stckCnt), 32'd16);

    // Backtrack twice from a full stack
    readFromStack = 1; #1;
    chk("nxt_top16", 32'(nxtLoc), 32'hF0);
    cyc(1, 2'b00, 0, 1, 1, 0);
    chk("bt1_cnt", 32'(stckCnt), 32'd15);
    chk("bt1_full", 32'(fullStck), 32'd0);
    cyc(1, 2'b00, 0, 1, 1, 0);
    chk("bt2_cur",  32'(curLoc),  32'hE0);
    chk("bt2_cnt",  32'(stckCnt), 32'd14);
    chk("bt2_step", 32'(stepCnt), 32'd21);

    // Push+pop on non-empty stack overwrites top (was 0xD0)
    cyc(0, 2'b00, 1, 1, 0, 0);
    chk("ovw_cnt", 32'(stckCnt), 32'd14);
    readFromStack = 1; #1;
    chk("ovw_top", 32'(nxtLoc), 32'hE0);
    readFromStack = 0;
    cyc(1, 2'b01, 0, 0, 0, 0);
    chk("to_xmax", 32'(curLoc), 32'hF0);
    dir = 2'b01; #1;
    chk("edge_xinc", 32'(edgeHit), 32'd1);
    dir = 2'b10; #1;
    chk("noedge_xdec", 32'(edgeHit), 32'd0);

    // Asynchronous reset mid-cycle
    chk("pre_rst_ovf", 32'(ovfErr), 32'd1);
    #3 rst = 1;
    #1;
    chk("arst_cur",  32'(curLoc),  32'h00);
    chk("arst_cnt",  32'(stckCnt), 32'd0);
    chk("arst_step", 32'(stepCnt), 32'd0);
    chk("arst_errs", 32'({ovfErr, unfErr, bndErr}), 32'd0);
    cyc(1, 2'b01, 1, 0, 0, 0);
    chk("rst_blocks_ops", 32'({curLoc, 3'(stckCnt)}), 32'h000);
    rst = 0;

    // Backtrack test
    cyc(1, 2'b01, 0, 0, 0, 0);
    cyc(1, 2'b01, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 2'b11, 0, 0, 0, 0);
    chk("at_23", 32'(curLoc), 32'h23);
    cyc(0, 2'b00, 1, 0, 0, 0);
    cyc(1, 2'b01, 0, 0, 0, 0);
    chk("at_33", 32'(curLoc), 32'h33);
    cyc(1, 2'b00, 0, 1, 1, 0);
    chk("bt_cur", 32'(curLoc),  32'h23);
    chk("bt_emp", 32'(empStck), 32'd1);

    // Underflow test
    readFromStack = 1; #1;
    chk("nxt_emp_cur", 32'(nxtLoc), 32'h23);
    cyc(1, 2'b01, 0, 0, 1, 0);
    chk("unf_cur",  32'(curLoc),  32'h23);
    chk("unf_err",  32'(unfErr),  32'd1);
    chk("unf_step", 32'(stepCnt), 32'd7);
    cyc(0, 2'b00, 0, 0, 0, 1);
    chk("unf_clr", 32'(unfErr), 32'd0);
    cyc(0, 2'b00, 0, 1, 0, 0);
    chk("pop_emp_err", 32'(unfErr), 32'd1);
    chk("pop_emp_cnt", 32'(stckCnt), 32'd0);
    cyc(0, 2'b00, 1, 1, 0, 0);
    chk("pp_emp_cnt", 32'(stckCnt), 32'd1);
    readFromStack = 1; #1;
    chk("pp_emp_top", 32'(nxtLoc), 32'h23);
    readFromStack = 0;

    // Walk to the goal corner
    for (int i = 0; i < 13; i++) cyc(1, 2'b01, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(1, 2'b11, 0, 0, 0, 0);
    chk("goal_cur",  32'(curLoc),  32'hFF);
    chk("goal_flag", 32'(atGoal),  32'd1);
    chk("goal_step", 32'(stepCnt), 32'd32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
